// File: rtl/la_monitor_trig.sv
// Logic-analyser monitor: circular sample RAM with free-run or pattern
// trigger capture, readable and configurable over the slave bus.
module la_monitor_trig #(
   parameter int SIG_W  = 32,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [SIG_W-1:0]  SIGNALS,
   input  logic              step_en,
   input  logic              in_init,
   input  logic              stop_n,
   input  logic              CARDSEL,
   input  logic              WR_N,
   input  logic [ADDR_W+1:0] AI,
   input  logic [31:0]       SLAVE_D,
   output logic              SACK_N,
   output logic [31:0]       SLAVE_OUTPUT,
   output logic [1:0]        la_state,
   output logic              la_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_POST  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE = 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] trig_addr;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  remaining;
   logic              wrapped;

   logic              mode;
   logic [SIG_W-1:0]  trig_mask;
   logic [SIG_W-1:0]  trig_val;
   logic [CNT_W-1:0]  post_cnt;

   logic [SIG_W-1:0]  ram [2**ADDR_W];

   logic              cap;
   logic              hit;
   logic [1:0]        region;
   logic [31:0]       rd_mux;

   assign la_state = state;
   assign la_done  = (state == S_DONE);
   assign region   = AI[ADDR_W+1:ADDR_W];

   assign cap = !in_init && stop_n &&
                ((state == S_ARMED) || (state == S_POST));
   assign hit = ((SIGNALS & trig_mask) == (trig_val & trig_mask));

   always_ff @(posedge CLK) begin
      if (cap) ram[wr_ptr] <= SIGNALS;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         trig_addr  <= '0;
         sample_cnt <= '0;
         remaining  <= '0;
         wrapped    <= 1'b0;
      end else if (in_init) begin
         state <= S_IDLE;
      end else if (state == S_IDLE) begin
         if (step_en) begin
            state      <= S_ARMED;
            wr_ptr     <= '0;
            sample_cnt <= '0;
            wrapped    <= 1'b0;
         end
      end else if (cap) begin
         wr_ptr <= wr_ptr + PTR_ONE;
         if (wr_ptr == PTR_MAX) wrapped <= 1'b1;
         if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + CNT_ONE;
         if (state == S_ARMED) begin
            if (mode && hit) begin
               trig_addr <= wr_ptr;
               remaining <= post_cnt;
               state     <= (post_cnt == '0) ? S_DONE : S_POST;
            end
         end else begin
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) state <= S_DONE;
         end
      end
   end

   // Config is frozen outside IDLE so a running capture cannot be retargeted.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mode      <= 1'b0;
         trig_mask <= '0;
         trig_val  <= '0;
         post_cnt  <= '0;
      end else if (CARDSEL && !WR_N && region == 2'b10 &&
                   state == S_IDLE) begin
         unique case (AI[1:0])
            2'd0: mode      <= SLAVE_D[0];
            2'd1: trig_mask <= SLAVE_D[SIG_W-1:0];
            2'd2: trig_val  <= SLAVE_D[SIG_W-1:0];
            2'd3: post_cnt  <= SLAVE_D[CNT_W-1:0];
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (region)
         2'b00: rd_mux = 32'(ram[AI[ADDR_W-1:0]]);
         2'b01: begin
            unique case (AI[1:0])
               2'd0: rd_mux = {28'b0, wrapped, la_done, state};
               2'd1: rd_mux = 32'(wr_ptr);
               2'd2: rd_mux = 32'(trig_addr);
               2'd3: rd_mux = 32'(sample_cnt);
            endcase
         end
         2'b10: begin
            unique case (AI[1:0])
               2'd0: rd_mux = {31'b0, mode};
               2'd1: rd_mux = 32'(trig_mask);
               2'd2: rd_mux = 32'(trig_val);
               2'd3: rd_mux = 32'(post_cnt);
            endcase
         end
         2'b11: rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         SACK_N       <= 1'b1;
         SLAVE_OUTPUT <= '0;
      end else begin
         SACK_N <= ~CARDSEL;
         if (CARDSEL && WR_N) SLAVE_OUTPUT <= rd_mux;
      end
   end

endmodule

// File: doc/la_monitor_trig.md
Name: la_monitor_trig

Overview:
- Parametrised logic-analyser monitor for the Extended DLX board.
- Samples a SIG_W-wide probe bus into a circular on-chip RAM of 2^ADDR_W entries.
- Capture modes: free-run, and pattern-triggered with programmable post-trigger depth.
- Samples, status and config are readable, and config is writable, over the existing slave bus (CARDSEL/WR_N/AI/SACK_N), so the host can reconstruct pre- and post-trigger history.

Parameters:
SIG_W, 32, probe bus width; legal range 1..32, zero-extended on read.
ADDR_W, 10, log2 of capture depth; legal range 4..12.
CNT_W, 16, width of post-trigger count and total sample counter.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  synchronous, active-high; clears all state and config.
SIGNALS  in  SIG_W  probe bus being sampled.
step_en  in  1  arm pulse; IDLE->ARMED when in_init=0.
in_init  in  1  1 = init/readout phase; forces IDLE, preserves RAM and pointers.
stop_n  in  1  0 = pause capture (no write, no pointer or counter change).
CARDSEL  in  1  slave select.
WR_N  in  1  0 = slave write, 1 = slave read.
AI  in  ADDR_W+2  slave address; [ADDR_W+1:ADDR_W] region, low bits index.
SLAVE_D  in  32  slave write data.
SACK_N  out  1  slave acknowledge, active low.
SLAVE_OUTPUT  out  32  registered slave read data.
la_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
la_done  out  1  1 while in DONE.

Behaviour:
Reset
- RESET=1: state IDLE, wr_ptr=0, trig_addr=0, sample_cnt=0, wrapped=0.
- Config cleared: mode=0, TRIG_MASK=0, TRIG_VAL=0, POST_CNT=0.
- SACK_N=1, SLAVE_OUTPUT=0, la_done=0.
- RAM contents undefined after reset.
- Precedence: RESET > in_init > step_en > capture.

State machine
- IDLE -> ARMED: step_en=1 and in_init=0; same cycle clears wr_ptr, sample_cnt, wrapped. No sample written on the arming cycle.
- Capture: in ARMED or POST, stop_n=1 -> RAM[wr_ptr]<=SIGNALS, wr_ptr<=wr_ptr+1 mod 2^ADDR_W, sample_cnt++ (saturates at all-ones). On wrap to 0, wrapped<=1.
- ARMED -> POST: mode[0]=1 and the written sample satisfies (SIGNALS & TRIG_MASK)==(TRIG_VAL & TRIG_MASK). Latch trig_addr=address of that sample, remaining=POST_CNT. If POST_CNT=0, go directly to DONE.
- With mode[0]=0 (free-run) the block stays in ARMED until in_init.
- TRIG_MASK=0 in trigger mode triggers on the first written sample.
- POST: each written sample decrements remaining; the write that takes it to 0 moves to DONE.
- POST_CNT >= 2^ADDR_W overwrites the trigger sample; this is legal, and trig_addr still reports the original address.
- DONE: no writes; holds until in_init=1.
- in_init=1 in any state: next state IDLE; RAM, wr_ptr, trig_addr, wrapped, sample_cnt held.

Slave interface
- SACK_N goes 0 the cycle after CARDSEL is sampled 1, stays 0 while CARDSEL=1, and returns to 1 the cycle after CARDSEL=0.
- Read (WR_N=1): SLAVE_OUTPUT updates 1 cycle after the AI sample and is valid when SACK_N=0.
- Region 00: RAM[AI[ADDR_W-1:0]], zero-extended. Same-cycle capture write to the read address returns the old data.
- Region 01, index AI[1:0]:
  - 0 = {28'b0, wrapped, la_done, la_state}
  - 1 = wr_ptr
  - 2 = trig_addr
  - 3 = sample_cnt
- Region 10, index AI[1:0] (read back): 0 mode, 1 TRIG_MASK, 2 TRIG_VAL, 3 POST_CNT.
- Region 11 reads 0.
- Write (WR_N=0, CARDSEL=1): region 10 register <= SLAVE_D, truncated to its width.
  - Accepted only in IDLE; otherwise ignored but still acknowledged.
  - Writes to other regions are ignored.

Test Plan:
1. RESET pulse -> la_state=0, SACK_N=1, SLAVE_OUTPUT=0; region 10 index 1 reads 0.
2. Free-run, ADDR_W=4:
   - Stimulus: arm, drive SIGNALS=1..20 for 20 cycles, stop_n=0 for 2 cycles mid-run, then in_init=1.
   - Required: wr_ptr=4 (20 mod 16), wrapped=1, sample_cnt=20.
   - Required: RAM[3]=20, RAM[4]=5.
   - Required: paused cycles not stored.
3. Trigger mode:
   - Config: mode=1, TRIG_MASK=0xFF, TRIG_VAL=0x07, POST_CNT=3.
   - Stimulus: SIGNALS counts 1,2,...
   - Required: trig_addr=6, DONE after sample 10, wr_ptr=10; writes stop in DONE.
4. POST_CNT=0, TRIG_VAL=0x02 -> DONE in the cycle after sample 2 is written; wr_ptr=2, la_done=1.
5. Config write while ARMED:
   - Stimulus: write TRIG_VAL=0x55.
   - Required: SACK_N still asserted, TRIG_VAL unchanged.
   - Required: the same write in IDLE reads back 0x55.
6. in_init=1 mid-POST -> IDLE next cycle; RAM and trig_addr readable. step_en re-arm clears wr_ptr to 0. RESET during ARMED -> IDLE and config=0 next cycle.
